// File: rtl/uart_rx_frame_assembler.sv
// rtl/uart_rx_frame_assembler.sv - UART receive frame assembler (start/data/parity/stop tracking)
//
// Consumes one voted bit per BIT_AVAILABLE strobe and walks the frame:
// start, DATA_WIDTH data bits LSB first, optional parity, stop.
// Optional feature macro: UART_RX_ERR_CNT_EN (saturating parity/stop error counters).
//
// Ports:
//   CLK            receive oversampling clock
//   RST            asynchronous active-low reset
//   SAMPLED_BIT    voted bit value, meaningful while BIT_AVAILABLE=1
//   BIT_AVAILABLE  one-cycle strobe, one bit consumed per high cycle
//   PAR_EN         frame carries a parity bit (sampled at start bit)
//   PAR_TYP        0 even / 1 odd parity (sampled at start bit)
//   ERR_CNT_CLR    synchronous clear of both error counters (macro only)
//   P_DATA         last correctly received word
//   DATA_VALID     one-cycle strobe, P_DATA updated
//   PAR_ERR        one-cycle strobe, parity mismatch
//   STP_ERR        one-cycle strobe, stop bit sampled 0
//   STRT_GLITCH    one-cycle strobe, start bit sampled 1
//   BUSY           frame in progress
//   PAR_ERR_CNT    saturating parity error count (macro only)
//   STP_ERR_CNT    saturating stop error count (macro only)

module uart_rx_frame_assembler #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  SAMPLED_BIT,
    input  logic                  BIT_AVAILABLE,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
`ifdef UART_RX_ERR_CNT_EN
    input  logic                  ERR_CNT_CLR,
    output logic [7:0]            PAR_ERR_CNT,
    output logic [7:0]            STP_ERR_CNT,
`endif
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR,
    output logic                  STRT_GLITCH,
    output logic                  BUSY
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t                state, state_next;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_bad;
    logic                  cfg_par_en;
    logic                  cfg_par_typ;
    logic                  dv_next, pe_next, se_next, sg_next;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        dv_next    = 1'b0;
        pe_next    = 1'b0;
        se_next    = 1'b0;
        sg_next    = 1'b0;
        if (BIT_AVAILABLE) begin
            case (state)
                IDLE: begin
                    if (!SAMPLED_BIT) begin
                        state_next = DATA;
                    end else begin
                        sg_next = 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == LAST_BIT) begin
                        state_next = cfg_par_en ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    state_next = STOP;
                end
                STOP: begin
                    state_next = IDLE;
                    dv_next    = SAMPLED_BIT && !par_bad;
                    pe_next    = par_bad;
                    se_next    = !SAMPLED_BIT;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt         <= '0;
            shreg       <= '0;
            par_bad     <= 1'b0;
            cfg_par_en  <= 1'b0;
            cfg_par_typ <= 1'b0;
            P_DATA      <= '0;
            DATA_VALID  <= 1'b0;
            PAR_ERR     <= 1'b0;
            STP_ERR     <= 1'b0;
            STRT_GLITCH <= 1'b0;
            BUSY        <= 1'b0;
        end else begin
            DATA_VALID  <= dv_next;
            PAR_ERR     <= pe_next;
            STP_ERR     <= se_next;
            STRT_GLITCH <= sg_next;
            // Registered BUSY tracks the state register it is derived from.
            BUSY        <= (state_next != IDLE);
            if (BIT_AVAILABLE) begin
                case (state)
                    IDLE: begin
                        if (!SAMPLED_BIT) begin
                            shreg       <= '0;
                            cnt         <= '0;
                            par_bad     <= 1'b0;
                            cfg_par_en  <= PAR_EN;
                            cfg_par_typ <= PAR_TYP;
                        end
                    end
                    DATA: begin
                        // LSB arrives first, so shifting in at the top leaves it at bit 0.
                        shreg <= {SAMPLED_BIT, shreg[DATA_WIDTH-1:1]};
                        cnt   <= (cnt == LAST_BIT) ? '0 : cnt + CW'(1);
                    end
                    PARITY: begin
                        par_bad <= (SAMPLED_BIT != (^shreg ^ cfg_par_typ));
                    end
                    STOP: begin
                        par_bad <= 1'b0;
                        if (dv_next) begin
                            P_DATA <= shreg;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

`ifdef UART_RX_ERR_CNT_EN
    // Counters step on the same edge that raises their strobe.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            PAR_ERR_CNT <= 8'd0;
            STP_ERR_CNT <= 8'd0;
        end else if (ERR_CNT_CLR) begin
            PAR_ERR_CNT <= 8'd0;
            STP_ERR_CNT <= 8'd0;
        end else begin
            if (pe_next && (PAR_ERR_CNT != 8'hFF)) begin
                PAR_ERR_CNT <= PAR_ERR_CNT + 8'd1;
            end
            if (se_next && (STP_ERR_CNT != 8'hFF)) begin
                STP_ERR_CNT <= STP_ERR_CNT + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_frame_assembler.sv
// tb/tb_uart_rx_frame_assembler.sv - scoreboard bench for uart_rx_frame_assembler

module tb_uart_rx_frame_assembler;

    localparam logic [3:0] K_DV = 4'b1000;
    localparam logic [3:0] K_PE = 4'b0100;
    localparam logic [3:0] K_SE = 4'b0010;
    localparam logic [3:0] K_SG = 4'b0001;

    typedef struct {
        logic [3:0] kind;
        logic [7:0] pdata;
        int         due;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       SAMPLED_BIT = 1'b1;
    logic       BIT_AVAILABLE = 1'b0;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [7:0] P_DATA;
    logic       DATA_VALID, PAR_ERR, STP_ERR, STRT_GLITCH, BUSY;
`ifdef UART_RX_ERR_CNT_EN
    logic       ERR_CNT_CLR = 1'b0;
    logic [7:0] PAR_ERR_CNT, STP_ERR_CNT;
`endif

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   gap = 1;
    exp_t q[$];

    uart_rx_frame_assembler #(.DATA_WIDTH(8)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .SAMPLED_BIT  (SAMPLED_BIT),
        .BIT_AVAILABLE(BIT_AVAILABLE),
        .PAR_EN       (PAR_EN),
        .PAR_TYP      (PAR_TYP),
`ifdef UART_RX_ERR_CNT_EN
        .ERR_CNT_CLR  (ERR_CNT_CLR),
        .PAR_ERR_CNT  (PAR_ERR_CNT),
        .STP_ERR_CNT  (STP_ERR_CNT),
`endif
        .P_DATA       (P_DATA),
        .DATA_VALID   (DATA_VALID),
        .PAR_ERR      (PAR_ERR),
        .STP_ERR      (STP_ERR),
        .STRT_GLITCH  (STRT_GLITCH),
        .BUSY         (BUSY)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every strobe event must match the head of the scoreboard queue.
    always @(negedge CLK) begin
        if (RST && (DATA_VALID || PAR_ERR || STP_ERR || STRT_GLITCH)) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_strobe: got kind=%b p_data=%h expected none",
                         {DATA_VALID, PAR_ERR, STP_ERR, STRT_GLITCH}, P_DATA);
            end else begin
                exp_t e;
                e = q.pop_front();
                if ({DATA_VALID, PAR_ERR, STP_ERR, STRT_GLITCH} !== e.kind ||
                    P_DATA !== e.pdata || cyc != e.due) begin
                    failures++;
                    $display("FAIL strobe_event: got kind=%b p_data=%h cyc=%0d expected kind=%b p_data=%h cyc=%0d",
                             {DATA_VALID, PAR_ERR, STP_ERR, STRT_GLITCH}, P_DATA, cyc,
                             e.kind, e.pdata, e.due);
                end
            end
        end
    end

    // Called at a negedge; leaves control at a later negedge.
    task automatic send_bit(input logic b);
        BIT_AVAILABLE = 1'b1;
        SAMPLED_BIT   = b;
        @(negedge CLK);
        if (gap != 0) begin
            BIT_AVAILABLE = 1'b0;
            repeat (gap) @(negedge CLK);
        end
    endtask

    task automatic push_exp(input logic [3:0] kind, input logic [7:0] pd);
        exp_t e;
        e.kind  = kind;
        e.pdata = pd;
        e.due   = cyc + 1;
        q.push_back(e);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt,
                              input logic pbit, input logic stop,
                              input logic [3:0] kind, input logic [7:0] pd);
        PAR_EN  = pe;
        PAR_TYP = pt;
        send_bit(1'b0);
        if (gap != 0) check("busy_mid_frame", {15'd0, BUSY}, 16'd1);
        // Configuration changes after the start bit must be ignored.
        PAR_EN  = ~pe;
        PAR_TYP = ~pt;
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (pe) send_bit(pbit);
        push_exp(kind, pd);
        send_bit(stop);
        BIT_AVAILABLE = 1'b0;
        SAMPLED_BIT   = 1'b1;
        @(negedge CLK);
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        check("reset_busy",   {15'd0, BUSY}, 16'd0);
        check("reset_pdata",  {8'd0, P_DATA}, 16'h0000);
        check("reset_strobe", {12'd0, DATA_VALID, PAR_ERR, STP_ERR, STRT_GLITCH}, 16'd0);
        RST = 1'b1;
        @(negedge CLK);

        // 1: no parity
        gap = 1;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, K_DV, 8'hA5);
        check("idle_busy_after_frame", {15'd0, BUSY}, 16'd0);

        // 2: even parity, held-high strobe back to back
        gap = 0;
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, K_DV, 8'h3C);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, K_PE, 8'h3C);
        check("pdata_kept_after_par_err", {8'd0, P_DATA}, 16'h003C);

        // 3: odd parity
        gap = 2;
        send_frame(8'h01, 1'b1, 1'b1, 1'b0, 1'b1, K_DV, 8'h01);

        // 4: stop error
        gap = 1;
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, K_SE, 8'h01);
        check("pdata_kept_after_stp_err", {8'd0, P_DATA}, 16'h0001);
`ifdef UART_RX_ERR_CNT_EN
        check("par_cnt_one", {8'd0, PAR_ERR_CNT}, 16'd1);
        check("stp_cnt_one", {8'd0, STP_ERR_CNT}, 16'd1);
        gap = 0;
        for (int i = 0; i < 255; i++)
            send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, K_SE, 8'h01);
        check("stp_cnt_saturated", {8'd0, STP_ERR_CNT}, 16'd255);
        ERR_CNT_CLR = 1'b1;
        @(negedge CLK);
        ERR_CNT_CLR = 1'b0;
        check("stp_cnt_cleared", {8'd0, STP_ERR_CNT}, 16'd0);
        check("par_cnt_cleared", {8'd0, PAR_ERR_CNT}, 16'd0);
        gap = 1;
`endif

        // 5: start glitch, then a normal frame
        push_exp(K_SG, 8'h01);
        send_bit(1'b1);
        check("busy_after_glitch", {15'd0, BUSY}, 16'd0);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, K_DV, 8'hFF);

        // 6: reset mid-frame
        PAR_EN = 1'b0;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        BIT_AVAILABLE = 1'b0;
        RST = 1'b0;
        #1;
        check("abort_busy",   {15'd0, BUSY}, 16'd0);
        check("abort_pdata",  {8'd0, P_DATA}, 16'h0000);
        check("abort_strobe", {12'd0, DATA_VALID, PAR_ERR, STP_ERR, STRT_GLITCH}, 16'd0);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, K_DV, 8'h81);

        // Parity and stop errors together
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, K_PE | K_SE, 8'h81);

        repeat (5) @(negedge CLK);
        check("scoreboard_drained", 16'(q.size()), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
